// File: rtl/map_ram_loader.sv
// Map RAM loader: a serial frame receiver that writes one map row per frame.
// The map is readable combinationally; border cells can be forced to wall.
module map_ram_loader #(
    parameter int MAP_WIDTH_BITS  = 4,
    parameter int MAP_HEIGHT_BITS = 4,
    parameter int LOCK_BORDER     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_sclk,
    input  logic                       i_mosi,
    input  logic                       i_ss_n,
    input  logic [MAP_WIDTH_BITS-1:0]  i_col,
    input  logic [MAP_HEIGHT_BITS-1:0] i_row,
    output logic                       o_val,
    output logic                       o_busy,
    output logic                       o_wr_strobe,
    output logic                       o_frame_err
);

    localparam int COL_COUNT  = 1 << MAP_WIDTH_BITS;
    localparam int ROW_COUNT  = 1 << MAP_HEIGHT_BITS;
    localparam int FRAME_BITS = MAP_HEIGHT_BITS + COL_COUNT;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    // Reset contents of one row: walls on the outer ring, open interior.
    function automatic logic [COL_COUNT-1:0] border_row(input int r);
        logic [COL_COUNT-1:0] v;
        if (r == 0 || r == ROW_COUNT - 1) begin
            v = '1;
        end else begin
            v = '0;
            v[0] = 1'b1;
            v[COL_COUNT-1] = 1'b1;
        end
        return v;
    endfunction

    state_t                               r_state, w_next_state;
    logic [CNT_W-1:0]                     r_cnt, w_next_cnt;
    // Holds the first FRAME_BITS-1 bits; the last bit is taken straight from mosi.
    logic [FRAME_BITS-2:0]                r_shift, w_next_shift;
    logic                                 r_err, w_err;
    logic                                 w_wr_en;
    logic [ROW_COUNT-1:0][COL_COUNT-1:0]  r_map;
    logic [2:0]                           r_sclk_sync;
    logic [1:0]                           r_mosi_sync;
    logic [1:0]                           r_ss_sync;

    logic                       w_sclk_rise;
    logic                       w_mosi;
    logic                       w_ss_n;
    logic [FRAME_BITS-1:0]      w_frame;
    logic [MAP_HEIGHT_BITS-1:0] w_wr_row;
    logic [COL_COUNT-1:0]       w_wr_data;
    logic                       w_border;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_mosi      = r_mosi_sync[1];
    assign w_ss_n      = r_ss_sync[1];
    assign w_frame     = {r_shift, w_mosi};
    assign w_wr_row    = w_frame[FRAME_BITS-1 -: MAP_HEIGHT_BITS];
    assign w_wr_data   = w_frame[COL_COUNT-1:0];

    // Bring the serial bus into the clk domain; idle levels on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 3'b000;
            r_mosi_sync <= 2'b00;
            r_ss_sync   <= 2'b11;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[0], i_mosi};
            r_ss_sync   <= {r_ss_sync[0], i_ss_n};
        end
    end

    // Frame FSM: next state, counter, shift data, write and abort decisions.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_shift = r_shift;
        w_wr_en      = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_ss_n) begin
                    w_next_state = SHIFT;
                    w_next_cnt   = '0;
                end
            end
            SHIFT, COMMIT: begin
                if (w_ss_n) begin
                    // Frame select dropped: discard any partial frame.
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                    w_err        = (r_cnt != '0);
                end else begin
                    w_next_state = SHIFT;
                    if (w_sclk_rise) begin
                        w_next_shift = w_frame[FRAME_BITS-2:0];
                        if (r_cnt == LAST_BIT) begin
                            w_wr_en      = 1'b1;
                            w_next_cnt   = '0;
                            w_next_state = COMMIT;
                        end else begin
                            w_next_cnt = r_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM state, bit counter, shift register and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_shift <= w_next_shift;
            r_err   <= w_err;
        end
    end

    // Map storage: reset to the walled pattern, one row written per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROW_COUNT; r++) begin
                r_map[r] <= border_row(r);
            end
        end else if (w_wr_en) begin
            r_map[w_wr_row] <= w_wr_data;
        end
    end

    assign w_border = (i_col == '0) || (i_col == '1) || (i_row == '0) || (i_row == '1);

    assign o_val       = r_map[i_row][i_col] | ((LOCK_BORDER != 0) && w_border);
    assign o_busy      = (r_state != IDLE);
    assign o_wr_strobe = (r_state == COMMIT);
    assign o_frame_err = r_err;

endmodule

// File: tb/tb_map_ram_loader.sv
// Bench for map_ram_loader: two instances (border locked / unlocked) share
// one serial bus; a cell-array model predicts every read.
module tb_map_ram_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_sclk = 1'b0;
    logic       i_mosi = 1'b0;
    logic       i_ss_n = 1'b1;
    logic [3:0] i_col = '0;
    logic [3:0] i_row = '0;
    logic       val1, busy1, strb1, err1;
    logic       val0, busy0, strb0, err0;

    int n_chk = 0;
    int n_err = 0;
    int n_strb = 0;
    int n_ferr = 0;

    logic [15:0] mdl [16];
    logic        exp_c1, exp_c0;

    map_ram_loader #(.MAP_WIDTH_BITS(4), .MAP_HEIGHT_BITS(4), .LOCK_BORDER(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_sclk(i_sclk), .i_mosi(i_mosi), .i_ss_n(i_ss_n),
        .i_col(i_col), .i_row(i_row), .o_val(val1), .o_busy(busy1),
        .o_wr_strobe(strb1), .o_frame_err(err1)
    );

    map_ram_loader #(.MAP_WIDTH_BITS(4), .MAP_HEIGHT_BITS(4), .LOCK_BORDER(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_sclk(i_sclk), .i_mosi(i_mosi), .i_ss_n(i_ss_n),
        .i_col(i_col), .i_row(i_row), .o_val(val0), .o_busy(busy0),
        .o_wr_strobe(strb0), .o_frame_err(err0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_border(input int c, input int r);
        return (c == 0) || (c == 15) || (r == 0) || (r == 15);
    endfunction

    function automatic logic exp_cell(input int c, input int r, input logic lock);
        return mdl[r][c] | (lock & is_border(c, r));
    endfunction

    task automatic reset_model();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                mdl[r][c] = is_border(c, r);
    endtask

    // Count pulses and check the freshly written cell in the commit cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (strb1) begin
                n_strb++;
                chk("commit_val1", val1, exp_c1);
                chk("commit_val0", val0, exp_c0);
            end
            if (err1) n_ferr++;
            if (strb0 | strb1 | err0 | err1)
                chk("pair_pulses", {strb0, err0}, {strb1, err1});
        end
    end

    task automatic send_bit(input logic b, input logic last, input logic old1, input logic old0);
        i_mosi = b;
        #40;
        if (last) begin
            chk("old_val1", val1, old1);
            chk("old_val0", val0, old0);
        end
        i_sclk = 1'b1;
        #40;
        i_sclk = 1'b0;
    endtask

    task automatic ss_begin();
        i_ss_n = 1'b0;
        #40;
    endtask

    task automatic ss_end();
        #40;
        i_ss_n = 1'b1;
        #200;
    endtask

    task automatic send_frame(input logic [3:0] row, input logic [15:0] data);
        logic [19:0] f;
        logic        o1, o0;
        int          c;
        f = {row, data};
        c = $urandom_range(0, 15);
        i_row = row;
        i_col = 4'(c);
        o1 = exp_cell(c, row, 1'b1);
        o0 = exp_cell(c, row, 1'b0);
        exp_c1 = data[c] | is_border(c, row);
        exp_c0 = data[c];
        for (int i = 19; i >= 0; i--) begin
            send_bit(f[i], i == 0, o1, o0);
            if (i == 10) chk("busy_mid", {busy1, busy0}, 2'b11);
        end
        mdl[row] = data;
    endtask

    task automatic one_frame(input logic [3:0] row, input logic [15:0] data);
        int s0;
        s0 = n_strb;
        ss_begin();
        send_frame(row, data);
        ss_end();
        chk("strobes_1", n_strb - s0, 1);
    endtask

    task automatic abort_frame(input int k);
        int s0, e0;
        s0 = n_strb;
        e0 = n_ferr;
        ss_begin();
        for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        ss_end();
        chk("abort_strb", n_strb - s0, 0);
        chk("abort_err", n_ferr - e0, 1);
        chk("abort_busy", busy1, 0);
    endtask

    task automatic sweep();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                i_col = 4'(c);
                i_row = 4'(r);
                #1;
                chk($sformatf("val1_c%0d_r%0d", c, r), val1, exp_cell(c, r, 1'b1));
                chk($sformatf("val0_c%0d_r%0d", c, r), val0, exp_cell(c, r, 1'b0));
            end
    endtask

    task automatic spot(input int c, input int r, input logic e1, input logic e0);
        i_col = 4'(c);
        i_row = 4'(r);
        #1;
        chk($sformatf("spot1_c%0d_r%0d", c, r), val1, e1);
        chk($sformatf("spot0_c%0d_r%0d", c, r), val0, e0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "bench timeout");
    end

    initial begin
        int s0, e0, k;
        logic [19:0] f;
        reset_model();
        #35;
        rst_n = 1'b1;
        #50;
        // Reset state.
        chk("rst_busy", busy1, 0);
        chk("rst_strb", strb1, 0);
        chk("rst_err", err1, 0);
        sweep();

        // Row 5 = 0x0F0F.
        one_frame(4'd5, 16'h0F0F);
        spot(0, 5, 1, 1);
        spot(3, 5, 1, 1);
        spot(4, 5, 0, 0);
        spot(8, 5, 1, 1);
        sweep();

        // Back-to-back frames under one select.
        s0 = n_strb;
        ss_begin();
        send_frame(4'd2, 16'hFFFF);
        send_frame(4'd3, 16'h0000);
        ss_end();
        chk("strobes_2", n_strb - s0, 2);
        spot(0, 3, 1, 0);
        spot(7, 3, 0, 0);
        spot(15, 3, 1, 0);
        sweep();

        // Clearing border row 0: locked instance still reads walls.
        one_frame(4'd0, 16'h0000);
        spot(6, 0, 1, 0);
        sweep();

        // Abort after 11 bits, then a full frame.
        abort_frame(11);
        sweep();
        one_frame(4'd9, 16'hA5C3);
        sweep();

        // Reset in the middle of a row 7 frame.
        s0 = n_strb;
        e0 = n_ferr;
        ss_begin();
        f = {4'd7, 16'h1234};
        for (int i = 19; i > 4; i--) send_bit(f[i], 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        i_ss_n = 1'b1;
        #20;
        chk("rst_mid_busy_low", busy1, 0);
        rst_n = 1'b1;
        #100;
        chk("rst_mid_strb", n_strb - s0, 0);
        chk("rst_mid_err", n_ferr - e0, 0);
        chk("rst_mid_busy", busy1, 0);
        reset_model();
        sweep();

        // Randomized mix of single, paired and aborted frames.
        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 2))
                0: one_frame(4'($urandom_range(0, 15)), 16'($urandom));
                1: begin
                    s0 = n_strb;
                    ss_begin();
                    send_frame(4'($urandom_range(0, 15)), 16'($urandom));
                    send_frame(4'($urandom_range(0, 15)), 16'($urandom));
                    ss_end();
                    chk("rnd_strobes_2", n_strb - s0, 2);
                end
                default: begin
                    k = $urandom_range(1, 19);
                    abort_frame(k);
                end
            endcase
            sweep();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/map_ram_loader.md
MAP_RAM_LOADER -- requirements
Module: map_ram_loader

Interface
REQ-001 Parameter MAP_WIDTH_BITS, default 4, SHALL set the column index width; COL_COUNT = 2^MAP_WIDTH_BITS.
REQ-002 Parameter MAP_HEIGHT_BITS, default 4, SHALL set the row index width; ROW_COUNT = 2^MAP_HEIGHT_BITS.
REQ-003 Parameter LOCK_BORDER, default 1, SHALL force border cells to read 1 when set to 1; border cells are col 0, col COL_COUNT-1, row 0 and row ROW_COUNT-1.
REQ-004 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 i_sclk  input  1  serial load clock, asynchronous to clk; its rate SHALL be at most clk/6.
REQ-007 i_mosi  input  1  serial load data, asynchronous to clk.
REQ-008 i_ss_n  input  1  serial frame select, active-low, asynchronous to clk.
REQ-009 i_col  input  MAP_WIDTH_BITS  read column index.
REQ-010 i_row  input  MAP_HEIGHT_BITS  read row index.
REQ-011 o_val  output  1  map cell value at (i_col, i_row); 1 = wall.
REQ-012 o_busy  output  1  high while state is SHIFT or COMMIT.
REQ-013 o_wr_strobe  output  1  one-cycle pulse per committed row.
REQ-014 o_frame_err  output  1  one-cycle pulse per aborted partial frame.

Function
REQ-015 Storage SHALL be ROW_COUNT row registers, each COL_COUNT bits wide; bit c of row r holds cell (c, r).
REQ-016 o_val SHALL be a combinational read of storage at (i_col, i_row), ORed with the border term when LOCK_BORDER=1.
REQ-017 i_sclk, i_mosi and i_ss_n SHALL each pass through a 2-flop synchronizer; an sclk rising edge is detected from a third flop on the synchronized sclk.
REQ-018 The FSM SHALL have three states: IDLE, SHIFT and COMMIT.
REQ-019 IDLE->SHIFT SHALL occur when synchronized ss_n is low; the bit counter is zeroed on entry.
REQ-020 In SHIFT and COMMIT, each detected sclk rising edge SHALL shift synchronized mosi into the frame shift register MSB-first and increment the bit counter.
REQ-021 Frame length SHALL be FRAME_BITS = MAP_HEIGHT_BITS + COL_COUNT (default 20): first the row address, MSB first; then row data, bit COL_COUNT-1 first, bit 0 last.
REQ-022 On the clk edge that accepts bit FRAME_BITS, the addressed row register SHALL be written, the counter zeroed and the FSM set to COMMIT.
REQ-023 In COMMIT, o_wr_strobe SHALL be 1, and new data SHALL be visible on o_val in that same cycle.
REQ-024 COMMIT SHALL last exactly one cycle, then go to SHIFT if synchronized ss_n is low, else to IDLE; back-to-back frames within one ss_n assertion SHALL be supported.
REQ-025 Synchronized ss_n rising while the counter is nonzero SHALL discard the partial frame with no write, pulse o_frame_err for one cycle, zero the counter and return to IDLE.
REQ-026 Synchronized ss_n rising with the counter at zero SHALL return to IDLE silently.
REQ-027 sclk edges while in IDLE SHALL be ignored.
REQ-028 A read of the row being written SHALL return the old value until the write edge and the new value from the COMMIT cycle on.
REQ-029 Extra bits beyond a frame SHALL start the next frame; there is no overflow condition.

Reset
REQ-030 While rst_n is low, the FSM SHALL be in IDLE, the counter and shift register 0, and o_busy, o_wr_strobe and o_frame_err 0.
REQ-031 While rst_n is low, storage SHALL hold border cells = 1 and interior cells = 0, regardless of LOCK_BORDER.
REQ-032 Asserting rst_n mid-frame SHALL abort the frame without a write and without an o_frame_err pulse.
REQ-033 Synchronizer flops SHALL reset to the idle bus levels: sclk 0, mosi 0, ss_n 1.

Verification
REQ-034 Reset release, sweep all 256 (col, row) -> o_val = 1 exactly on the borders, 0 elsewhere; o_busy = 0.
REQ-035 One frame: row 5, data 0x0F0F -> single o_wr_strobe; (0,5) = 1, (3,5) = 1, (4,5) = 0, (8,5) = 1; other rows unchanged.
REQ-036 Two frames under one ss_n assertion (row 2 = 0xFFFF, then row 3 = 0x0000) -> two strobes; row 2 all 1s; row 3 reads 1 only at cols 0 and 15 with LOCK_BORDER=1.
REQ-037 Row 0 = 0x0000 with LOCK_BORDER=1 -> row 0 still reads all 1s; same frame with LOCK_BORDER=0 -> row 0 reads all 0s.
REQ-038 ss_n raised after 11 bits -> one o_frame_err pulse, no strobe, storage unchanged; the next full frame commits correctly.
REQ-039 rst_n pulsed low after 15 bits of a row 7 frame -> no strobe, no o_frame_err, storage returns to the reset pattern, o_busy = 0.
